ppe_sequencer: RTL and testbench

Clocked controller that sequences one partial PE (PPE): decodes incoming 33-bit NoC packets, loads filter weights and input rows into the external weight and input register files, and runs the 1-D sliding-window MAC over each row. It emits one partial-sum packet per window position, round-robin across the SPEs, and requests the next input row from IMEM until a timestep's rows are exhausted. It sits between the PPE's router port and its two register files.

---
 rtl/ppe_sequencer_if.sv | 25 ++
 rtl/ppe_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_ppe_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppe_sequencer_if.sv
// Packet port bundle between a PPE router port and the PPE sequencer.
//
// Handshake: a word moves on a rising clk edge where valid && ready are both
// high. The sender holds valid and data stable until that edge; ready may
// change freely and never depends combinationally on valid.
interface ppe_sequencer_if;
    logic        pkt_in_valid;
    logic        pkt_in_ready;
    logic [32:0] pkt_in_data;
    logic        pkt_out_valid;
    logic        pkt_out_ready;
    logic [32:0] pkt_out_data;

    // Sequencer side: consumes pkt_in, produces pkt_out.
    modport slave (
        input  pkt_in_valid, pkt_in_data, pkt_out_ready,
        output pkt_in_ready, pkt_out_valid, pkt_out_data
    );

    // Router side: produces pkt_in, consumes pkt_out.
    modport master (
        output pkt_in_valid, pkt_in_data, pkt_out_ready,
        input  pkt_in_ready, pkt_out_valid, pkt_out_data
    );
endinterface

// File: rtl/ppe_sequencer.sv
// Partial-PE sequencer: decodes NoC packets, fills the weight and input
// register files, runs the 1-D sliding-window MAC per input row and emits
// one partial-sum packet per window, round-robin over the SPEs, followed by
// an IMEM request for the next row while the timestep still has rows left.
module ppe_sequencer #(
    parameter int         FILTER_SIZE  = 5,
    parameter int         IFMAP_SIZE   = 25,
    parameter int         WEIGHT_WIDTH = 8,
    parameter int         SUM_WIDTH    = 14,
    parameter int         NUM_ROWS     = 5,
    parameter int         NUM_SPE      = 5,
    parameter logic [3:0] PE_ID        = 4'd0,
    parameter logic [3:0] IMEM_ID      = 4'd10
) (
    input  logic                    clk,
    input  logic                    reset,
    ppe_sequencer_if.slave          bus,
    output logic                    w_we,
    output logic [2:0]              w_waddr,
    output logic [WEIGHT_WIDTH-1:0] w_wdata,
    output logic [2:0]              w_raddr,
    input  logic [WEIGHT_WIDTH-1:0] w_rdata,
    output logic                    i_we,
    output logic [IFMAP_SIZE-1:0]   i_wdata,
    output logic [4:0]              i_raddr,
    input  logic                    i_rdata,
    output logic [1:0]              ts,
    output logic [2:0]              row_cnt,
    output logic                    err,
    output logic [2:0]              dbg_state
);
    localparam int OUTPUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;

    typedef enum logic [2:0] {IDLE, WLOAD, ILOAD, MAC, DRAIN, EMIT, REQ} state_t;

    state_t                       state;
    logic [2:0]                   wptr;
    logic [1:0]                   wcnt;
    logic [15:0]                  wbuf;
    logic [2:0]                   tap;
    logic [4:0]                   win;
    logic [2:0]                   spe_ptr;
    logic signed [SUM_WIDTH-1:0]  acc;
    logic signed [SUM_WIDTH-1:0]  w_ext;
    logic signed [SUM_WIDTH-1:0]  acc_next;
    logic [3:0]                   opcode;

    assign opcode    = bus.pkt_in_data[28:25];
    assign dbg_state = state;
    assign w_ext     = {{(SUM_WIDTH-WEIGHT_WIDTH){w_rdata[WEIGHT_WIDTH-1]}}, w_rdata};

    // Accumulator including the RF pair returned this cycle (taken iff input bit is 1).
    always_comb begin
        acc_next = acc;
        if (i_rdata) acc_next = acc + w_ext;
    end

    // Main sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            bus.pkt_in_ready  <= 1'b1;
            bus.pkt_out_valid <= 1'b0;
            bus.pkt_out_data  <= '0;
            w_we              <= 1'b0;
            w_waddr           <= '0;
            w_wdata           <= '0;
            w_raddr           <= '0;
            i_we              <= 1'b0;
            i_wdata           <= '0;
            i_raddr           <= '0;
            ts                <= 2'd1;
            row_cnt           <= '0;
            err               <= 1'b0;
            wptr              <= '0;
            wcnt              <= '0;
            wbuf              <= '0;
            tap               <= '0;
            win               <= '0;
            spe_ptr           <= '0;
            acc               <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pkt_in_valid && bus.pkt_in_ready) begin
                        case (opcode)
                            4'd0: begin
                                // Byte 0 goes out now; bytes 1 and 2 follow from wbuf.
                                state            <= WLOAD;
                                bus.pkt_in_ready <= 1'b0;
                                w_we             <= 1'b1;
                                w_waddr          <= wptr;
                                w_wdata          <= bus.pkt_in_data[7:0];
                                wbuf             <= bus.pkt_in_data[23:8];
                                wcnt             <= 2'd1;
                            end
                            4'd1: begin
                                if (row_cnt < 3'(NUM_ROWS)) begin
                                    state            <= ILOAD;
                                    bus.pkt_in_ready <= 1'b0;
                                    i_we             <= 1'b1;
                                    i_wdata          <= bus.pkt_in_data[IFMAP_SIZE-1:0];
                                end else begin
                                    // Timestep already full: drop the row.
                                    err <= 1'b1;
                                end
                            end
                            4'd15: begin
                                row_cnt <= '0;
                                ts      <= ts + 2'd1;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                WLOAD: begin
                    if (wcnt == 2'd3) begin
                        // Two 3-byte halves fill addresses 0..5 alternately.
                        w_we             <= 1'b0;
                        wptr             <= (wptr >= 3'd3) ? 3'd0 : 3'd3;
                        state            <= IDLE;
                        bus.pkt_in_ready <= 1'b1;
                    end else begin
                        w_waddr <= w_waddr + 3'd1;
                        w_wdata <= wbuf[7:0];
                        wbuf    <= {8'd0, wbuf[15:8]};
                        wcnt    <= wcnt + 2'd1;
                    end
                end
                ILOAD: begin
                    i_we    <= 1'b0;
                    row_cnt <= row_cnt + 3'd1;
                    win     <= '0;
                    tap     <= '0;
                    acc     <= '0;
                    w_raddr <= '0;
                    i_raddr <= '0;
                    state   <= MAC;
                end
                MAC: begin
                    // Read data lags the address by one cycle, so tap 0 has nothing to add yet.
                    if (tap != 3'd0) acc <= acc_next;
                    if (tap == 3'(FILTER_SIZE-1)) begin
                        state <= DRAIN;
                    end else begin
                        tap     <= tap + 3'd1;
                        w_raddr <= tap + 3'd1;
                        i_raddr <= win + 5'(tap) + 5'd1;
                    end
                end
                DRAIN: begin
                    acc               <= acc_next;
                    state             <= EMIT;
                    bus.pkt_out_valid <= 1'b1;
                    bus.pkt_out_data  <= {1'b0, spe_ptr, 4'd0,
                                          {(IFMAP_SIZE-SUM_WIDTH){acc_next[SUM_WIDTH-1]}}, acc_next};
                end
                EMIT: begin
                    if (bus.pkt_out_ready) begin
                        bus.pkt_out_valid <= 1'b0;
                        spe_ptr           <= (spe_ptr == 3'(NUM_SPE-1)) ? 3'd0 : spe_ptr + 3'd1;
                        win               <= win + 5'd1;
                        if (win + 5'd1 < 5'(OUTPUT_DIM)) begin
                            state   <= MAC;
                            tap     <= '0;
                            acc     <= '0;
                            w_raddr <= '0;
                            i_raddr <= win + 5'd1;
                        end else if (row_cnt < 3'(NUM_ROWS)) begin
                            state             <= REQ;
                            bus.pkt_out_valid <= 1'b1;
                            bus.pkt_out_data  <= {IMEM_ID, PE_ID, 25'd0};
                        end else begin
                            state            <= IDLE;
                            bus.pkt_in_ready <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.pkt_out_ready) begin
                        bus.pkt_out_valid <= 1'b0;
                        state             <= IDLE;
                        bus.pkt_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state            <= IDLE;
                    bus.pkt_in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ppe_sequencer.sv
// Bench for ppe_sequencer: directed test-plan steps plus random rows/weights,
// with a packet-level reference model and expected-packet queue.
module tb_ppe_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        w_we, i_we, i_rdata, err;
    logic [2:0]  w_waddr, w_raddr, row_cnt, dbg_state;
    logic [7:0]  w_wdata, w_rdata;
    logic [24:0] i_wdata;
    logic [4:0]  i_raddr;
    logic [1:0]  ts;

    ppe_sequencer_if bus();

    ppe_sequencer dut (
        .clk(clk), .reset(reset), .bus(bus),
        .w_we(w_we), .w_waddr(w_waddr), .w_wdata(w_wdata),
        .w_raddr(w_raddr), .w_rdata(w_rdata),
        .i_we(i_we), .i_wdata(i_wdata), .i_raddr(i_raddr), .i_rdata(i_rdata),
        .ts(ts), .row_cnt(row_cnt), .err(err), .dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // External register files: registered read, data valid the cycle after the address.
    logic [7:0]  wrf [0:7];
    logic [24:0] irow;
    initial begin
        for (int i = 0; i < 8; i++) wrf[i] = 8'd0;
        irow = '0;
    end
    always @(posedge clk) begin
        if (w_we) wrf[w_waddr] <= w_wdata;
        if (i_we) irow <= i_wdata;
        w_rdata <= wrf[w_raddr];
        i_rdata <= irow[i_raddr];
    end

    // Scoreboard state and reference model.
    logic [32:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          req_cyc = 0;
    int          n_out = 0;
    int          we_cnt = 0;
    int          ready_mode = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_data = '0;

    logic [7:0]  wm [0:5];
    int          wptr_m = 0;
    int          rows_m = 0;
    int          spe_m = 0;
    logic [1:0]  ts_m = 2'd1;
    logic        err_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: drives pkt_out_ready and checks every accepted packet.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(bus.pkt_out_valid), 64'd1);
                chk("hold_data", 64'(bus.pkt_out_data), 64'(prev_data));
            end
            if (w_we || i_we) we_cnt++;
            case (ready_mode)
                0:       bus.pkt_out_ready = 1'b1;
                1:       bus.pkt_out_ready = 1'($urandom_range(0, 1));
                default: bus.pkt_out_ready = 1'b0;
            endcase
            if (bus.pkt_out_valid && bus.pkt_out_ready) begin
                n_out++;
                n_cmp++;
                assert (exp_q.size() > 0) else begin
                    n_err++;
                    $error("FAIL unexpected_pkt observed=%0h expected=none", bus.pkt_out_data);
                end
                if (exp_q.size() > 0) chk("pkt", 64'(bus.pkt_out_data), 64'(exp_q.pop_front()));
                if (bus.pkt_out_data[32:25] == {4'd10, 4'd0}) req_cyc = cyc;
            end
            prev_stall = bus.pkt_out_valid && !bus.pkt_out_ready;
            prev_data  = bus.pkt_out_data;
        end
    end

    function automatic void model_row(input logic [24:0] row);
        int s;
        if (rows_m >= 5) begin
            err_m = 1'b1;
            return;
        end
        rows_m++;
        for (int win = 0; win < 21; win++) begin
            s = 0;
            for (int t = 0; t < 5; t++)
                if (row[win + t]) s += int'($signed(wm[t]));
            exp_q.push_back({1'b0, 3'(spe_m), 4'd0, 25'(s)});
            spe_m = (spe_m + 1) % 5;
        end
        if (rows_m < 5) exp_q.push_back({4'd10, 4'd0, 25'd0});
    endfunction

    function automatic void model_reset();
        wptr_m = 0; rows_m = 0; spe_m = 0; ts_m = 2'd1; err_m = 1'b0;
        exp_q.delete();
    endfunction

    // Driver: present one input packet and return after it has been accepted.
    task automatic send_pkt(input logic [3:0] op, input logic [24:0] d);
        int n = 0;
        @(negedge clk);
        bus.pkt_in_valid = 1'b1;
        bus.pkt_in_data  = {4'($urandom), op, d};
        while (!bus.pkt_in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        assert (n < 3000) else begin
            n_err++;
            $error("FAIL send_timeout observed=%0d expected<3000", n);
        end
        acc_cyc = cyc;
        @(negedge clk);
        bus.pkt_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(bus.pkt_in_ready && !bus.pkt_out_valid && exp_q.size() == 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        assert (n < 5000) else begin
            n_err++;
            $error("FAIL idle_timeout observed=%0d left=%0d expected=0", n, exp_q.size());
        end
    endtask

    task automatic send_w(input logic [24:0] d);
        send_pkt(4'd0, d);
        for (int k = 0; k < 3; k++) wm[wptr_m + k] = d[8*k +: 8];
        wptr_m = (wptr_m == 3) ? 0 : 3;
        wait_idle();
    endtask

    task automatic send_row(input logic [24:0] d);
        send_pkt(4'd1, d);
        model_row(d);
        wait_idle();
    endtask

    task automatic send_ts();
        send_pkt(4'd15, 25'($urandom));
        rows_m = 0;
        ts_m   = ts_m + 2'd1;
        wait_idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.pkt_in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus.pkt_out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(bus.pkt_out_data), 64'd0);
        chk({tag, "_we"}, 64'({w_we, i_we}), 64'd0);
        chk({tag, "_addr"}, 64'({w_waddr, w_raddr, i_raddr}), 64'd0);
        chk({tag, "_ts"}, 64'(ts), 64'd1);
        chk({tag, "_row_cnt"}, 64'(row_cnt), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int n0, w0;
        bus.pkt_in_valid = 1'b0;
        bus.pkt_in_data  = '0;
        for (int i = 0; i < 6; i++) wm[i] = 8'd0;

        // Reset state.
        do_reset();

        // Weights 1..5, all-ones row: sums 15, dests 0..4 repeating, then IMEM request.
        send_w(25'h030201);
        send_w(25'h000504);
        send_row(25'h1FFFFFF);
        chk("row_latency", 64'(req_cyc - acc_cyc), 64'd149);
        send_row(25'h0000001);
        send_row(25'h1000000);
        chk("row_cnt_3", 64'(row_cnt), 64'(rows_m));

        // Rows 4 and 5 with random back-pressure; row 5 has no IMEM request.
        ready_mode = 1;
        send_row(25'($urandom));
        send_row(25'($urandom));
        ready_mode = 0;
        chk("row_cnt_full", 64'(row_cnt), 64'd5);

        // Sixth row is dropped with err.
        n0 = n_out;
        send_pkt(4'd1, 25'h1FFFFFF);
        model_row(25'h1FFFFFF);
        repeat (20) @(negedge clk);
        chk("drop_err", 64'(err), 64'(err_m));
        chk("drop_no_out", 64'(n_out), 64'(n0));

        // Timestep done.
        send_ts();
        chk("ts_row_cnt", 64'(row_cnt), 64'd0);
        chk("ts_val", 64'(ts), 64'(ts_m));

        // All weights -1, all-ones rows: sums -5; second row starts one SPE later.
        do_reset();
        send_w(25'h0FFFFFF);
        send_w(25'h0FFFFFF);
        send_row(25'h1FFFFFF);
        send_row(25'h1FFFFFF);

        // Hold ready low for 10 cycles while a result waits in EMIT.
        ready_mode = 2;
        send_pkt(4'd1, 25'($urandom));
        model_row(bus.pkt_in_data[24:0]);
        for (int n = 0; n < 200 && !bus.pkt_out_valid; n++) @(negedge clk);
        chk("stall_valid", 64'(bus.pkt_out_valid), 64'd1);
        n0 = n_out;
        repeat (10) @(negedge clk);
        chk("stall_no_pkt", 64'(n_out), 64'(n0));
        ready_mode = 0;
        wait_idle();

        // Random weights and rows with random back-pressure.
        ready_mode = 1;
        for (int i = 0; i < 3; i++) send_w(25'($urandom));
        send_row(25'($urandom));
        send_row(25'($urandom));
        ready_mode = 0;
        chk("rows_done", 64'(row_cnt), 64'(rows_m));
        send_ts();
        chk("ts_after_reset", 64'(ts), 64'(ts_m));

        // Unknown opcode: consumed, err set, no RF writes, no output.
        n0 = n_out;
        w0 = we_cnt;
        send_pkt(4'd7, 25'($urandom));
        err_m = 1'b1;
        repeat (10) @(negedge clk);
        chk("op7_err", 64'(err), 64'(err_m));
        chk("op7_no_we", 64'(we_cnt), 64'(w0));
        chk("op7_no_out", 64'(n_out), 64'(n0));
        chk("op7_ready", 64'(bus.pkt_in_ready), 64'd1);

        // Reset in the middle of a window.
        ready_mode = 2;
        send_pkt(4'd1, 25'($urandom));
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midreset");
        reset = 1'b0;
        model_reset();
        ready_mode = 0;

        // Recovery after reset: one more random row starting at SPE 0.
        send_row(25'($urandom));
        chk("final_row_cnt", 64'(row_cnt), 64'd1);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
